booth_serial_mult_param: RTL

//  Parametrised serial radix-4 Booth multiplier, signed or unsigned per operation.

---
 rtl/booth_serial_mult_param.sv | 138 +++++++++++++
 1 files changed

// File: rtl/booth_serial_mult_param.sv
// Serial radix-4 Booth multiplier, one Booth digit per clock, signed/unsigned per op.
// Define BOOTH_MAC_EN to add an in_c addend and an ACC state (out_p = a*b + c).
module booth_serial_mult_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef BOOTH_MAC_EN
  input  logic [2*WIDTH-1:0] in_c,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int ITER = WIDTH/2 + 1;
  localparam int E    = WIDTH + 2;
  localparam int H    = WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);

`ifdef BOOTH_MAC_EN
  typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;
  logic [2*WIDTH-1:0] c_r;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [E-1:0]    a_r;
  logic [H-1:0]    hi;
  logic [E-1:0]    lo;
  logic            guard;

  logic [2:0]      win;
  logic [H-1:0]    ax, op, sum;
  logic            neg;
  logic [H+E-1:0]  shifted;

  assign win = {lo[1:0], guard};
  assign ax  = {{2{a_r[E-1]}}, a_r};

  always_comb begin
    op  = '0;
    neg = 1'b0;
    case (win)
      3'b001, 3'b010: op = ax;
      3'b011:         op = ax << 1;
      3'b100:         begin op = ax << 1; neg = 1'b1; end
      3'b101, 3'b110: begin op = ax;      neg = 1'b1; end
      default:        ;
    endcase
  end

  // Subtraction as ~op + 1 folded into one adder.
  assign sum     = hi + (neg ? ~op : op) + {{(H-1){1'b0}}, neg};
  assign shifted = {{2{sum[H-1]}}, sum, lo[E-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_r       <= '0;
      hi        <= '0;
      lo        <= '0;
      guard     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_p     <= '0;
`ifdef BOOTH_MAC_EN
      c_r       <= '0;
`endif
    end else if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
          lo       <= in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
          hi       <= '0;
          guard    <= 1'b0;
          cnt      <= '0;
`ifdef BOOTH_MAC_EN
          c_r      <= in_c;
`endif
          state    <= CALC;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        CALC: begin
          // ITER digit cycles, then one cycle to publish the product.
          if (cnt != CW'(ITER)) begin
            hi    <= shifted[H+E-1:E];
            lo    <= shifted[E-1:0];
            guard <= lo[1];
            cnt   <= cnt + CW'(1);
          end else begin
            cnt <= '0;
`ifdef BOOTH_MAC_EN
            state <= ACC;
`else
            out_p     <= {hi[WIDTH-3:0], lo};
            out_valid <= 1'b1;
            state     <= DONE;
`endif
          end
        end
`ifdef BOOTH_MAC_EN
        ACC: begin
          out_p     <= {hi[WIDTH-3:0], lo} + c_r;
          out_valid <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
